// File: rtl/button_event.sv
// button_event: debounces a synchronized pushbutton level and turns it into one-cycle strobes.
//   Clk           in   system clock, all state updates on posedge
//   Reset_n       in   asynchronous active-low reset
//   btn           in   synchronized button level, 1 = pressed
//   clr           in   synchronous clear of press_count
//   pressed       out  debounced level
//   press_pulse   out  one-cycle strobe on debounced rising edge
//   release_pulse out  one-cycle strobe on debounced falling edge
//   long_pulse    out  one-cycle strobe after HOLD_CYCLES of hold
//   repeat_pulse  out  periodic strobe every REPEAT_CYCLES after long_pulse
//   press_count   out  wrapping count of press events
module button_event #(
   parameter int STABLE_CYCLES = 4,
   parameter int HOLD_CYCLES   = 16,
   parameter int REPEAT_CYCLES = 8,
   parameter int CNT_W         = 16
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       btn,
   input  logic       clr,
   output logic       pressed,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic [7:0] press_count
);
   typedef enum logic [1:0] {RELEASED, HELD_SHORT, HELD_LONG} state_t;
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt, r_tmr;
   logic               r_pressed, r_press_p, r_rel_p, r_long_p, r_rep_p;
   logic [7:0]         r_count;
   logic [CNT_W-1:0]   w_cnt_nx, w_tmr_nx;
   logic               w_diff, w_flip, w_rise, w_fall;
   assign w_cnt_nx = r_cnt + 1'b1;
   assign w_tmr_nx = r_tmr + 1'b1;
   assign w_diff   = btn != r_pressed;
   // the filtered level flips on the edge where the disagreement count would reach STABLE_CYCLES
   assign w_flip   = w_diff && (w_cnt_nx == CNT_W'(STABLE_CYCLES));
   assign w_rise   = w_flip && !r_pressed;
   assign w_fall   = w_flip && r_pressed;
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= RELEASED;
         r_cnt     <= '0;
         r_tmr     <= '0;
         r_pressed <= 1'b0;
         r_press_p <= 1'b0;
         r_rel_p   <= 1'b0;
         r_long_p  <= 1'b0;
         r_rep_p   <= 1'b0;
         r_count   <= '0;
      end else begin
         r_press_p <= w_rise;
         r_rel_p   <= w_fall;
         r_long_p  <= 1'b0;
         r_rep_p   <= 1'b0;
         r_cnt     <= (w_diff && !w_flip) ? w_cnt_nx : '0;
         if (w_flip) r_pressed <= !r_pressed;
         if (clr) r_count <= '0;
         else if (w_rise) r_count <= r_count + 8'd1;
         // release is checked first so it beats a timer expiry on the same edge
         if (w_fall) begin
            r_state <= RELEASED;
            r_tmr   <= '0;
         end else begin
            case (r_state)
               RELEASED: if (w_rise) begin
                  r_state <= HELD_SHORT;
                  r_tmr   <= '0;
               end
               HELD_SHORT: if (w_tmr_nx == CNT_W'(HOLD_CYCLES)) begin
                  r_long_p <= 1'b1;
                  r_tmr    <= '0;
                  r_state  <= HELD_LONG;
               end else r_tmr <= w_tmr_nx;
               HELD_LONG: if (w_tmr_nx == CNT_W'(REPEAT_CYCLES)) begin
                  r_rep_p <= 1'b1;
                  r_tmr   <= '0;
               end else r_tmr <= w_tmr_nx;
               default: r_state <= RELEASED;
            endcase
         end
      end
   end
   assign pressed       = r_pressed;
   assign press_pulse   = r_press_p;
   assign release_pulse = r_rel_p;
   assign long_pulse    = r_long_p;
   assign repeat_pulse  = r_rep_p;
   assign press_count   = r_count;
endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Consumes the synchronized pushbutton level produced by the board-input synchronizer.
- Applies a counter-based debounce filter to that level.
- Converts the filtered level into single-cycle events: press, release, long-press and auto-repeat.
- Keeps a wrapping press counter, so the control FSMs and register-load logic downstream see clean, one-cycle strobes instead of raw levels.

Parameters:
- STABLE_CYCLES, 4: consecutive sampled edges btn must differ from the filtered level before that level flips (>=1). Kept small for simulation; the top level overrides it for hardware.
- HOLD_CYCLES, 16: cycles after press_pulse until long_pulse (>=1).
- REPEAT_CYCLES, 8: period of repeat_pulse after long_pulse (>=1).
- CNT_W, 16: width of the internal timers; every cycle parameter must be < 2^CNT_W.

Ports:
- Clk  in  1  system clock, all state updates on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- btn  in  1  synchronized button level, 1 = pressed; already in the Clk domain.
- clr  in  1  synchronous clear of press_count.
- pressed  out  1  debounced level.
- press_pulse  out  1  one-cycle strobe on debounced rising edge.
- release_pulse  out  1  one-cycle strobe on debounced falling edge.
- long_pulse  out  1  one-cycle strobe when held HOLD_CYCLES.
- repeat_pulse  out  1  periodic one-cycle strobe while held past long.
- press_count  out  8  number of press events, wraps.

Behaviour:
- Reset:
  - Reset_n low asynchronously forces all outputs to 0, all timers to 0 and the FSM to RELEASED.
  - This takes effect regardless of Clk or btn.
- Filter counter:
  - At each posedge, if btn != pressed, the counter increments; otherwise it clears to 0.
  - On the edge where the counter would reach STABLE_CYCLES, pressed toggles and the counter clears.
  - Example: btn set high before edge 1 and held → pressed = 1 after edge STABLE_CYCLES.
  - Any single sample equal to pressed restarts the count, so a glitch shorter than STABLE_CYCLES produces no output change.
- press_pulse / release_pulse:
  - Registered outputs, high exactly in the cycle after the edge on which pressed toggles 0→1 / 1→0.
  - Never both high; never high for two consecutive cycles.
- FSM states: RELEASED, HELD_SHORT, HELD_LONG.
  - RELEASED → HELD_SHORT on filtered press; the hold timer is loaded with 0.
  - HELD_SHORT: the hold timer increments every cycle. When the timer reaches HOLD_CYCLES, long_pulse is high for one cycle (the cycle exactly HOLD_CYCLES after the press_pulse cycle). The timer then reloads to 0 and the FSM moves to HELD_LONG.
  - HELD_LONG: the timer increments every cycle. Each time it reaches REPEAT_CYCLES, repeat_pulse is high for one cycle and the timer reloads to 0. Repeats fall at press_pulse cycle + HOLD_CYCLES + k*REPEAT_CYCLES, k >= 1.
  - Any state → RELEASED on filtered release. The timer clears and no long_pulse or repeat_pulse is issued in or after the release_pulse cycle.
- Release racing a timer expiry: if the filtered release and a timer expiry fall on the same edge, release wins; no long_pulse or repeat_pulse is issued.
- press_count:
  - Increments by 1 in the same edge that raises press_pulse; 255 → 0 wraps.
  - clr has priority: clr high forces 0, even when a press coincides.
- Reset mid-operation: the block restarts in RELEASED. If btn is still high, a fresh press is detected after STABLE_CYCLES edges, with a new press_pulse and press_count = 1.
- STABLE_CYCLES = 1 degenerates to a one-edge register of btn with edge strobes.

Test Plan:
1. Reset_n = 0 with btn = 1 → all outputs 0. Release reset, keep btn = 1 → pressed = 1 and press_pulse high after edge 4 (one cycle only), press_count = 1.
2. Glitches: btn high for 3 edges then low; later btn high 2, low 1, high 4 → only one press_pulse, on the 4th edge of the final high run; pressed never rises before that.
3. Long hold, btn held 50 cycles past press_pulse (cycle P) → long_pulse at P+16, repeat_pulse at P+24, P+32, P+40, P+48, no other strobes.
4. Bouncy release: btn low 2, high 1, low 4 → exactly one release_pulse after the 4th consecutive low edge. pressed = 0 afterward; no repeat_pulse afterward.
5. Count wrap and clr:
   - 256 clean presses → press_count returns to 0.
   - clr asserted on the same edge as a press → press_count = 0 while press_pulse is still 1.
6. Reset_n pulsed low during HELD_LONG with btn high → outputs 0 immediately. After release of reset, press_pulse occurs 4 edges later and long_pulse 16 cycles after that.
